// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Contents: FSM state enum, default frame sync marker, packer byte-index type,
//           and the frame length legality check.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Index of the next byte within a 32-bit word (0 = MSB).
  typedef logic [1:0] byte_cnt_t;

  // A frame must carry at least one word and no more than the memory depth.
  function automatic logic len_ok(input logic [7:0] len, input int addr_w);
    return (len != 8'd0) && (int'(len) <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave  : loader side (consumes the stream, drives the memory write port).
// master : stream source / memory side (drives the stream, observes writes).
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_byte_packer.sv
// Assembles big-endian 32-bit words from bytes, MSB first.
// Ports: clk/RST (async active-high), clr (sync clear), shift + byte_in (one byte),
//        word_valid (one-cycle pulse the cycle after the 4th byte), word (assembled word).
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  byte_cnt_t idx;

  // The shift register doubles as the output word: it holds the complete word
  // exactly during the word_valid cycle, which is the only time it is consumed.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      idx        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      idx        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (shift) begin
        word       <= {word[23:0], byte_in};
        idx        <= idx + 1'b1;
        word_valid <= (idx == 2'd3);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction memory writes, checksum check,
// then releases the CPU from reset RST_HOLD cycles after a good frame.
// Ports: clk/RST (async active-high), bus (stream in + imem write port),
//        cpu_rstn (CPU reset, low = held), busy (frame in progress), done (CPU running), err (sticky).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 5,            // must be <= 7 (LEN byte holds 2**ADDR_W)
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         RST_HOLD  = 4             // must be >= 1
) (
  input  logic            clk,
  input  logic            RST,
  imem_loader_if.slave    bus,
  output logic            cpu_rstn,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  state_t state, state_n;

  logic [ADDR_W:0]   wcnt;      // words still to be written; one bit wider so 2**ADDR_W fits
  logic [ADDR_W-1:0] addr;
  logic [7:0]        xor_acc;
  logic [HOLD_W-1:0] hold_cnt;

  logic        accept;
  logic        is_sync;
  logic        last_wr;
  logic        csum_ok;
  logic        hold_done;
  logic        word_valid;
  logic [31:0] word;

  logic pk_clr, pk_shift, len_load, err_set, err_clr;

  assign bus.in_ready = (state != ST_RELEASE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_sync      = (bus.in_data == SYNC_BYTE);
  // Write cycle of the final word: every data byte is in, so a byte accepted
  // in this same cycle (full-rate stream) is already the checksum.
  assign last_wr      = word_valid && (wcnt == (ADDR_W + 1)'(1));
  assign csum_ok      = (bus.in_data == xor_acc);
  assign hold_done    = (hold_cnt == HOLD_W'(RST_HOLD - 1));

  imem_byte_packer u_packer (
    .clk        (clk),
    .RST        (RST),
    .clr        (pk_clr),
    .shift      (pk_shift),
    .byte_in    (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pk_clr   = 1'b0;
    pk_shift = 1'b0;
    len_load = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    unique case (state)
      ST_IDLE, ST_RUN: begin
        if (accept && is_sync) begin
          state_n = ST_LEN;
          pk_clr  = 1'b1;
          err_clr = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (len_ok(bus.in_data, ADDR_W)) begin
            state_n  = ST_DATA;
            len_load = 1'b1;
          end else begin
            state_n = ST_IDLE;
            err_set = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (last_wr) begin
          if (!accept) begin
            state_n = ST_CSUM;
          end else if (csum_ok) begin
            state_n = ST_RELEASE;
          end else begin
            state_n = ST_IDLE;
            err_set = 1'b1;
          end
        end else if (accept) begin
          pk_shift = 1'b1;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (csum_ok) begin
            state_n = ST_RELEASE;
          end else begin
            state_n = ST_IDLE;
            err_set = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (hold_done) state_n = ST_RUN;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wcnt     <= '0;
      addr     <= '0;
      xor_acc  <= '0;
      hold_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (pk_clr)        xor_acc <= '0;
      else if (pk_shift) xor_acc <= xor_acc ^ bus.in_data;

      // Address advances in the cycle after each write and wraps after 2**ADDR_W-1.
      if (len_load) begin
        wcnt <= bus.in_data[ADDR_W:0];
        addr <= '0;
      end else if (state == ST_DATA && word_valid) begin
        wcnt <= wcnt - 1'b1;
        addr <= addr + 1'b1;
      end

      if (state == ST_RELEASE) hold_cnt <= hold_cnt + 1'b1;
      else                     hold_cnt <= '0;

      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign bus.imem_we    = word_valid && (state == ST_DATA);
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = word;

  assign busy     = (state == ST_LEN) || (state == ST_DATA) ||
                    (state == ST_CSUM) || (state == ST_RELEASE);
  assign done     = (state == ST_RUN);
  assign cpu_rstn = (state == ST_RUN);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle MIPS CPU's instruction memory.
- Accepts a framed byte stream on a valid/ready interface and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory through a one-word write port and validates a checksum.
- Holds the CPU in reset throughout loading and releases it only after a good frame. This replaces hierarchical memory preloading with a synthesizable load path.

Parameters:
- ADDR_W, 5, instruction memory word-address width (depth 2**ADDR_W = 32 words).
- SYNC_BYTE, 8'hA5, frame start marker.
- RST_HOLD, 4, cycles the CPU stays in reset after checksum pass before release.

Ports:
- clk  in  1  system clock.
- RST  in  1  asynchronous, active-high reset. One clock domain (clk) only.
- in_data  in  8  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_rstn  out  1  drives CPU RSTn; 0 = CPU held in reset.
- busy  out  1  frame in progress (LEN/DATA/CSUM/RELEASE).
- done  out  1  level; program loaded and CPU running.
- err  out  1  sticky; last frame failed.

Behaviour:
- Reset (async, RST=1): state IDLE; cpu_rstn=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0; byte packer and checksum cleared. RST asserted mid-frame aborts the frame; partially written memory is not undone and the CPU stays in reset.
- Byte accept: a byte transfers when in_valid && in_ready. in_ready=1 in every state except RELEASE (0).
- Frame format: SYNC_BYTE, LEN, then LEN*4 data bytes (MSB first per word), then CSUM. CSUM equals the XOR of all data bytes; LEN is not included.
- IDLE: non-sync bytes are consumed and ignored. A sync byte goes to LEN and sets busy=1, err=0, cpu_rstn=0, done=0.
- LEN: LEN==0 or LEN>2**ADDR_W sets err=1 and returns to IDLE (busy=0). Otherwise the word counter is loaded, imem_addr=0, and the state goes to DATA.
- DATA: bytes shift into the packer MSB first.
  - On acceptance of the 4th byte of a word, imem_we=1 on the next cycle, with imem_wdata = the assembled word and imem_addr = the current word index.
  - imem_addr increments in the cycle after the write.
  - After the last word's write, the state goes to CSUM.
  - Back-to-back bytes at full rate must be accepted; no stall.
- CSUM: if the received byte equals the running XOR, go to RELEASE. Otherwise set err=1 and go to IDLE; busy=0 and cpu_rstn stays 0.
- RELEASE: count RST_HOLD cycles with cpu_rstn=0, then go to RUN.
- RUN: cpu_rstn=1, done=1, busy=0.
  - A sync byte in RUN re-enters LEN. cpu_rstn drops to 0 and done drops to 0 in the cycle after acceptance.
  - Other bytes in RUN are ignored.
- imem_we is never asserted outside DATA. At most one write occurs per 4 accepted data bytes.
- A sync-valued byte inside DATA/LEN/CSUM is treated as data; there is no resynchronisation mid-frame.
- The word counter is 1 bit wider than ADDR_W so LEN=2**ADDR_W is representable. The last address written is 2**ADDR_W-1, and imem_addr wraps to 0 after it.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN, DATA, CSUM, RELEASE, RUN);
  - the default SYNC_BYTE constant;
  - a byte-count type.
- Sub-module imem_byte_packer: shift register plus 2-bit byte index. It emits word_valid (one cycle) and word, and supports a synchronous clear.
- The top level holds the FSM, word counter, XOR accumulator, and hold counter.

Test Plan:
- Load 4 words: A5,04, bytes 20 03 00 80 20 04 00 0F AC 04 00 00 8C 05 00 00, CSUM A9 -> writes 20030080@0, 2004000F@1, AC040000@2, 8C050000@3. cpu_rstn rises RST_HOLD=4 cycles after CSUM acceptance; done=1, err=0.
- Same frame with CSUM 00 -> all 4 writes occur, then err=1, cpu_rstn stays 0, done=0, busy=0.
- LEN=00 and LEN=21 (hex) -> err=1, no imem_we, back to IDLE. LEN=20 with 128 bytes -> 32 writes, addr 0..1F.
- While in RUN, send A5,01,00000000,CSUM 00 -> cpu_rstn falls the cycle after A5 is accepted, one write of 0@0, CPU re-released after 4 cycles.
- Assert RST during DATA after 6 bytes -> all outputs at reset values immediately. A following full frame loads correctly starting at address 0.
- Garbage bytes 00 FF 12 before A5, and in_valid toggled randomly -> garbage ignored, identical writes to the first test, no dropped or duplicated bytes.
